fsm_step_scheduler: RTL and testbench

Round-robin scheduler that shares the 4-state x_in-driven state machine (s0..s3) among NREQ requesters. Each requester asks for a burst of K advance steps. The scheduler grants one requester at a time and drives the machine's x_in high for exactly K clocks. It tracks the expected machine state and checks it against the machine's next_state output, flagging any divergence.

---
 rtl/fsm_step_scheduler.sv | 103 ++++++++++
 tb/tb_fsm_step_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_step_scheduler.sv
// Round-robin burst scheduler for the shared x_in-driven 4-state machine.
// Grants one requester at a time, holds x_out high for that requester's step count and cross-checks the machine's next_state.
module fsm_step_scheduler #(
  parameter int NREQ = 4,
  parameter int CNTW = 4
) (
  input  logic                 clock,
  input  logic                 reset_b,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CNTW-1:0] steps,
  input  logic [1:0]           fsm_next_state,
  output logic                 x_out,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           pos,
  output logic                 mismatch
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  ctrl_state_t     state;
  logic [PW-1:0]   ptr;
  logic [CNTW-1:0] count;

  logic            found;
  logic [PW-1:0]   winner;
  logic [PW:0]     idx;
  logic [NREQ-1:0] winner_oh;
  logic [CNTW-1:0] winner_steps;
  logic [PW-1:0]   ptr_next;
  logic [1:0]      expected;

  // Machine sequence 00 -> 01 -> 11 -> 10 -> 00 (Gray order).
  function automatic logic [1:0] step_of(input logic [1:0] p);
    return {p[0], ~p[1]};
  endfunction

  // First set request scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  assign winner_oh    = {{(NREQ-1){1'b0}}, 1'b1} << winner;
  assign winner_steps = steps[winner*CNTW +: CNTW];
  assign ptr_next     = (winner == PW'(NREQ-1)) ? '0 : winner + PW'(1);

  assign x_out    = (state == RUN);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);
  assign expected = x_out ? step_of(pos) : pos;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      count    <= '0;
      pos      <= 2'b00;
      mismatch <= 1'b0;
    end else begin
      if (fsm_next_state != expected) mismatch <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            grant <= winner_oh;
            count <= winner_steps;
            ptr   <= ptr_next;
            state <= (winner_steps != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          pos   <= step_of(pos);
          count <= count - CNTW'(1);
          // Leaving at count==1 keeps count from ever wrapping below zero.
          if (count == CNTW'(1)) state <= DONE;
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_step_scheduler.sv
// Bench for fsm_step_scheduler: a behavioural machine plus a burst-level reference model
// predicting every cycle's grant/x_out/done/busy/pos/mismatch.
module tb_fsm_step_scheduler;

  localparam int NREQ = 4;
  localparam int CNTW = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset_b = 1'b0;
  always #5 clock = ~clock;

  logic [NREQ-1:0]      req;
  logic [NREQ*CNTW-1:0] steps;
  logic [1:0]           fsm_next_state;
  logic                 x_out, busy, done, mismatch;
  logic [NREQ-1:0]      grant;
  logic [1:0]           pos;

  fsm_step_scheduler #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clock          (clock),
    .reset_b        (reset_b),
    .req            (req),
    .steps          (steps),
    .fsm_next_state (fsm_next_state),
    .x_out          (x_out),
    .grant          (grant),
    .busy           (busy),
    .done           (done),
    .pos            (pos),
    .mismatch       (mismatch)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Machine states listed in stepping order; a state is an index into this table.
  logic [1:0] seq_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Controlled machine, with an override to inject a wrong next_state.
  int         mach_idx;
  logic       inject_en = 1'b0;
  logic [1:0] inject_val = 2'b00;
  always @(posedge clock or negedge reset_b) begin
    if (!reset_b) mach_idx <= 0;
    else if (x_out) mach_idx <= (mach_idx + 1) % 4;
  end
  always_comb begin
    fsm_next_state = inject_en ? inject_val : seq_tab[x_out ? (mach_idx + 1) % 4 : mach_idx];
  end

  // Reference model state
  int   m_ptr = 0;
  int   m_idx = 0;
  logic m_mis = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [NREQ-1:0] g, input logic x,
                              input logic d, input logic b);
    check_eq({tag, ".grant"},    32'(grant),    32'(g));
    check_eq({tag, ".x_out"},    32'(x_out),    32'(x));
    check_eq({tag, ".done"},     32'(done),     32'(d));
    check_eq({tag, ".busy"},     32'(busy),     32'(b));
    check_eq({tag, ".pos"},      32'(pos),      32'(seq_tab[m_idx]));
    check_eq({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
  endtask

  // One IDLE sampling cycle plus, if anyone requests, the whole burst and its DONE cycle.
  task automatic do_burst(input string tag, input logic [NREQ-1:0] r,
                          input logic [NREQ*CNTW-1:0] s, input bit scramble);
    int w, k, j;
    logic [NREQ-1:0] oh;
    req   = r;
    steps = s;
    expect_cycle({tag, "/idle"}, '0, 1'b0, 1'b0, 1'b0);
    if (r == '0) begin
      tick();
      return;
    end
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      j = (m_ptr + i) % NREQ;
      if (w < 0 && r[j]) w = j;
    end
    k = int'(s[w*CNTW +: CNTW]);
    oh = '0;
    oh[w] = 1'b1;
    m_ptr = (w + 1) % NREQ;
    for (int c = 0; c < k; c++) begin
      tick();
      if (scramble) begin
        req   = NREQ'($urandom);
        steps = (NREQ*CNTW)'($urandom);
      end
      expect_cycle({tag, "/run"}, oh, 1'b1, 1'b0, 1'b1);
      m_idx = (m_idx + 1) % 4;
    end
    tick();
    expect_cycle({tag, "/done"}, oh, 1'b0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic reset_dut(input string tag);
    req = '0;
    reset_b = 1'b0;
    #1;
    m_ptr = 0;
    m_idx = 0;
    m_mis = 1'b0;
    expect_cycle(tag, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_b = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] r;
    req = '0;
    steps = '0;
    repeat (2) @(posedge clock);
    #1;
    expect_cycle("reset", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_b = 1'b1;
    tick();

    // single requester, 3-step burst
    do_burst("t2", 4'b0001, 16'h0003, 1'b0);
    // two requesters held, one step each: alternate grants
    repeat (4) do_burst("t3", 4'b0101, 16'h1111, 1'b0);
    // zero-length burst goes straight to DONE
    do_burst("t4", 4'b0010, 16'h1101, 1'b0);
    // 4-step burst returns to start; 15-step burst from there
    reset_dut("t5_reset");
    do_burst("t5a", 4'b0001, 16'h0004, 1'b0);
    do_burst("t5b", 4'b0001, 16'h000F, 1'b0);

    // wrong next_state while pos=00 and x_out=0 sets the sticky flag
    reset_dut("t6_reset");
    req = '0;
    inject_en = 1'b1;
    inject_val = 2'b10;
    expect_cycle("t6_inject", '0, 1'b0, 1'b0, 1'b0);
    tick();
    inject_en = 1'b0;
    m_mis = 1'b1;
    expect_cycle("t6_flag", '0, 1'b0, 1'b0, 1'b0);
    do_burst("t6_hold", 4'b1000, 16'h5000, 1'b0);
    do_burst("t6_hold2", 4'b0110, 16'h0230, 1'b0);

    // reset in the middle of a 10-step burst
    req = 4'b0001;
    steps = 16'h000A;
    expect_cycle("t6b_idle", '0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_cycle("t6b_run", 4'b0001, 1'b1, 1'b0, 1'b1);
      m_idx = (m_idx + 1) % 4;
    end
    #2;
    req = '0;
    reset_b = 1'b0;
    #1;
    m_ptr = 0;
    m_idx = 0;
    m_mis = 1'b0;
    expect_cycle("t6b_async", '0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_cycle("t6b_nodone", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_b = 1'b1;
    tick();
    do_burst("t6b_restart", 4'b0001, 16'h0002, 1'b0);

    // randomized traffic with inputs disturbed mid-burst
    r = '0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) r = NREQ'($urandom);
      do_burst("rand", r, (NREQ*CNTW)'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
